fir_xifu_ctrl: RTL and testbench
================================

Name: fir_xifu_ctrl

Overview:
- Per-ID instruction scoreboard and issue gate for the FIR XIF unit (xfirlw / xfirsw / xfirdotp).
- Tracks the lifecycle of each XIF transaction ID and drives the issue/commit/kill vectors consumed by the EX and WB stages.
- Applies issue backpressure when an ID is still in use or the outstanding limit is reached.
- Sits between the ID stage, the core's XIF commit interface and the WB stage; it has no datapath of its own.

Parameters:
- X_ID_WIDTH, fir_xifu_pkg::X_ID_WIDTH (4): width of the XIF ID; X_ID_MAX = 2**X_ID_WIDTH.
- MAX_OUTSTANDING, X_ID_MAX (16): maximum number of non-FREE entries; legal range 1..X_ID_MAX.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- issue_valid_i  in  1  ID stage requests issue of issue_id_i.
- issue_id_i  in  X_ID_WIDTH  ID requested for issue.
- issue_ready_o  out  1  issue may be accepted this cycle (combinational).
- id2ctrl_i  in  fir_xifu_id2ctrl_t  accepted issue: .issue is valid only when issue_valid_i && issue_ready_o; .id equals issue_id_i.
- commit_valid_i  in  1  XIF commit strobe.
- commit_id_i  in  X_ID_WIDTH  ID being committed.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- wb2ctrl_i  in  fir_xifu_wb2ctrl_t  per-ID clear vector from WB.
- ctrl2ex_o  out  fir_xifu_ctrl2ex_t  issue/commit/kill vectors for EX.
- ctrl2wb_o  out  fir_xifu_ctrl2wb_t  same content as ctrl2ex_o.
- outstanding_o  out  X_ID_WIDTH+1  number of non-FREE entries.
- busy_o  out  1  outstanding_o != 0.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Per-ID 2-bit state register, one per ID, states FREE, ISSUED, COMMITTED, KILLED.
- Reset: all entries FREE, outstanding 0, err_o 0, and every output vector 0.
- issue_ready_o = (state[issue_id_i]==FREE) && (outstanding < MAX_OUTSTANDING). It is purely combinational from registers and issue_id_i, with no path from issue_valid_i.
- An issue is accepted when issue_valid_i && issue_ready_o && id2ctrl_i.issue. The entry goes FREE->ISSUED at the next edge.
- Commit (commit_valid_i, kill=0):
  - ISSUED->COMMITTED.
  - In any other state: no transition, and err_o is set.
- Kill (commit_valid_i, kill=1):
  - ISSUED->KILLED, or COMMITTED->KILLED.
  - FREE or KILLED: no transition, and err_o is set.
- Clear:
  - wb2ctrl_i.clear[i] on a COMMITTED entry: COMMITTED->FREE.
  - Clear on any other state: ignored, and err_o is set.
  - Multiple clear bits per cycle are legal.
- KILLED->FREE unconditionally after exactly one cycle. The kill bit is therefore visible for exactly one cycle.
- Output vectors are Moore outputs, decoded from state registers only:
  - issue[i] = ISSUED or COMMITTED.
  - commit[i] = COMMITTED.
  - kill[i] = KILLED.
- Latencies:
  - Issue accepted at edge t gives issue[id]=1 from cycle t+1.
  - Commit at t gives commit[id] from t+1.
  - Clear at t gives all bits 0 from t+1.
- Outstanding count:
  - outstanding_next = outstanding + accepted_issue - popcount(entries leaving to FREE).
  - It never wraps. It saturates at 0 and is bounded by MAX_OUTSTANDING by construction.
- Simultaneous events:
  - Issue and commit/clear on different IDs in the same cycle are all applied.
  - Commit and clear on the same COMMITTED ID: clear wins, the entry goes FREE, and no error.
  - Kill and clear on the same COMMITTED ID: kill wins, the entry goes KILLED, and the clear is dropped without error.
  - Issue to an ID that is freeing this cycle is not accepted, because ready is based on current state. The ID is re-accepted next cycle.
  - A commit in the same cycle as the issue of the same ID is a protocol error (the entry is still FREE): err_o is set and the issue is still accepted.
- Outstanding limit: when outstanding == MAX_OUTSTANDING, issue_ready_o = 0. It returns to 1 in the cycle after any entry becomes FREE.
- Reset mid-operation: all entries are forced FREE, err_o is cleared, and no kill pulses are generated.
- err_o clears only on reset.

Test Plan:
- Basic lifecycle: issue id 3, commit id 3 at t+2, clear[3] at t+4 -> issue[3] on t+1..t+4, commit[3] on t+3..t+4, all 0 at t+5; outstanding_o 0->1->0; err_o 0.
- Kill path: issue id 5, then kill id 5 -> kill[5]=1 for exactly one cycle, issue[5]=0 in that cycle, entry FREE after; re-issue of id 5 accepted the next cycle.
- Backpressure: MAX_OUTSTANDING=4, issue ids 0..3 without commit -> issue_ready_o=0 for id 4; commit+clear id 1 -> ready returns one cycle after clear; duplicate issue of id 2 while ISSUED -> ready=0.
- Simultaneous events: same cycle issue id 7 + commit id 2 + clear[0] with 0/2 preset COMMITTED/ISSUED -> all three applied, outstanding unchanged net (+1 -1); kill and clear same COMMITTED id -> KILLED, err_o 0.
- Protocol errors: commit id 9 while FREE -> err_o=1 sticky, state unchanged; clear[4] while ISSUED -> ignored, err_o stays 1 until rst_i.
- Reset mid-flight: 6 entries mixed ISSUED/COMMITTED, assert rst_i one cycle -> all vectors 0, outstanding_o 0, busy_o 0, err_o 0 next cycle; no kill pulses.

Source files
------------

// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIF unit: ID width and the control/EX/WB
// handshake structures.
package fir_xifu_pkg;

   localparam int X_ID_WIDTH = 4;
   localparam int X_ID_MAX   = 2**X_ID_WIDTH;

   typedef enum logic [1:0] {
      ST_FREE      = 2'd0,
      ST_ISSUED    = 2'd1,
      ST_COMMITTED = 2'd2,
      ST_KILLED    = 2'd3
   } fir_xifu_state_e;

   typedef struct packed {
      logic                  issue;
      logic [X_ID_WIDTH-1:0] id;
   } fir_xifu_id2ctrl_t;

   typedef struct packed {
      logic [X_ID_MAX-1:0] clear;
   } fir_xifu_wb2ctrl_t;

   typedef struct packed {
      logic [X_ID_MAX-1:0] issue;
      logic [X_ID_MAX-1:0] commit;
      logic [X_ID_MAX-1:0] kill;
   } fir_xifu_ctrl2ex_t;

   typedef fir_xifu_ctrl2ex_t fir_xifu_ctrl2wb_t;

endpackage

// File: rtl/fir_xifu_ctrl.sv
// Per-ID scoreboard and issue gate for the FIR XIF unit: tracks each
// transaction ID through FREE/ISSUED/COMMITTED/KILLED and throttles issue.
module fir_xifu_ctrl
   import fir_xifu_pkg::*;
#(
   parameter int X_ID_WIDTH      = fir_xifu_pkg::X_ID_WIDTH,
   parameter int MAX_OUTSTANDING = 2**X_ID_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  issue_valid_i,
   input  logic [X_ID_WIDTH-1:0] issue_id_i,
   output logic                  issue_ready_o,
   input  fir_xifu_id2ctrl_t     id2ctrl_i,
   input  logic                  commit_valid_i,
   input  logic [X_ID_WIDTH-1:0] commit_id_i,
   input  logic                  commit_kill_i,
   input  fir_xifu_wb2ctrl_t     wb2ctrl_i,
   output fir_xifu_ctrl2ex_t     ctrl2ex_o,
   output fir_xifu_ctrl2wb_t     ctrl2wb_o,
   output logic [X_ID_WIDTH:0]   outstanding_o,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int ID_MAX = 2**X_ID_WIDTH;
   localparam int CW     = X_ID_WIDTH + 1;
   localparam logic [CW-1:0] MAX_OUT_W = CW'(MAX_OUTSTANDING);

   logic [ID_MAX-1:0] free_now;
   logic [ID_MAX-1:0] leave_vec;
   logic [ID_MAX-1:0] err_vec;
   logic [ID_MAX-1:0] issue_vec;
   logic [ID_MAX-1:0] commit_vec;
   logic [ID_MAX-1:0] kill_vec;

   logic [CW-1:0] outstanding_reg, outstanding_next;
   logic [CW-1:0] leave_cnt;
   logic [CW:0]   sum_w;
   logic          err_reg;
   logic          issue_accept;

   assign issue_ready_o = free_now[issue_id_i] && (outstanding_reg < MAX_OUT_W);
   assign issue_accept  = issue_valid_i && issue_ready_o && id2ctrl_i.issue;

   for (genvar gi = 0; gi < ID_MAX; gi++) begin : g_entry
      fir_xifu_state_e state_reg, state_next;
      logic issue_hit, commit_hit, kill_hit, clear_hit;
      logic err_e, leave_e;

      assign issue_hit  = issue_accept && (id2ctrl_i.id == X_ID_WIDTH'(gi));
      assign commit_hit = commit_valid_i && !commit_kill_i && (commit_id_i == X_ID_WIDTH'(gi));
      assign kill_hit   = commit_valid_i &&  commit_kill_i && (commit_id_i == X_ID_WIDTH'(gi));
      assign clear_hit  = wb2ctrl_i.clear[gi];

      always_ff @(posedge clk_i) begin
         if (rst_i) state_reg <= ST_FREE;
         else       state_reg <= state_next;
      end

      always_comb begin
         state_next = state_reg;
         err_e      = 1'b0;
         leave_e    = 1'b0;
         unique case (state_reg)
            ST_FREE: begin
               if (issue_hit) state_next = ST_ISSUED;
               err_e = commit_hit || kill_hit || clear_hit;
            end
            ST_ISSUED: begin
               if (kill_hit)        state_next = ST_KILLED;
               else if (commit_hit) state_next = ST_COMMITTED;
               err_e = clear_hit;
            end
            ST_COMMITTED: begin
               // Kill beats clear; clear beats a redundant commit.
               if (kill_hit) begin
                  state_next = ST_KILLED;
               end else if (clear_hit) begin
                  state_next = ST_FREE;
                  leave_e    = 1'b1;
               end else begin
                  err_e = commit_hit;
               end
            end
            ST_KILLED: begin
               state_next = ST_FREE;
               leave_e    = 1'b1;
               err_e      = commit_hit || kill_hit || clear_hit;
            end
            default: state_next = ST_FREE;
         endcase
      end

      assign free_now[gi]   = (state_reg == ST_FREE);
      assign leave_vec[gi]  = leave_e;
      assign err_vec[gi]    = err_e;
      assign issue_vec[gi]  = (state_reg == ST_ISSUED) || (state_reg == ST_COMMITTED);
      assign commit_vec[gi] = (state_reg == ST_COMMITTED);
      assign kill_vec[gi]   = (state_reg == ST_KILLED);
   end

   always_comb begin
      leave_cnt = '0;
      for (int i = 0; i < ID_MAX; i++) leave_cnt = leave_cnt + CW'(leave_vec[i]);
      sum_w = {1'b0, outstanding_reg} + (CW+1)'(issue_accept);
      if (sum_w > {1'b0, leave_cnt}) outstanding_next = CW'(sum_w - {1'b0, leave_cnt});
      else                           outstanding_next = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding_reg <= '0;
         err_reg         <= 1'b0;
      end else begin
         outstanding_reg <= outstanding_next;
         if (|err_vec) err_reg <= 1'b1;
      end
   end

   assign ctrl2ex_o.issue  = issue_vec;
   assign ctrl2ex_o.commit = commit_vec;
   assign ctrl2ex_o.kill   = kill_vec;
   assign ctrl2wb_o        = ctrl2ex_o;
   assign outstanding_o    = outstanding_reg;
   assign busy_o           = (outstanding_reg != '0);
   assign err_o            = err_reg;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Directed bench for fir_xifu_ctrl: a full-size instance plus a
// 4-deep instance for the outstanding limit, both on shared stimulus.
module tb_fir_xifu_ctrl;
   import fir_xifu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic issue_valid = 1'b0;
   logic [3:0] issue_id = '0;
   fir_xifu_id2ctrl_t id2ctrl = '0;
   logic commit_valid = 1'b0;
   logic [3:0] commit_id = '0;
   logic commit_kill = 1'b0;
   fir_xifu_wb2ctrl_t wb2ctrl = '0;

   logic ready, ready4, busy, busy4, err, err4;
   fir_xifu_ctrl2ex_t ex, ex4;
   fir_xifu_ctrl2wb_t wb, wb4;
   logic [4:0] outs, outs4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fir_xifu_ctrl #(.X_ID_WIDTH(4), .MAX_OUTSTANDING(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .issue_valid_i(issue_valid), .issue_id_i(issue_id), .issue_ready_o(ready),
      .id2ctrl_i(id2ctrl),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .wb2ctrl_i(wb2ctrl), .ctrl2ex_o(ex), .ctrl2wb_o(wb),
      .outstanding_o(outs), .busy_o(busy), .err_o(err)
   );

   fir_xifu_ctrl #(.X_ID_WIDTH(4), .MAX_OUTSTANDING(4)) dut4 (
      .clk_i(clk), .rst_i(rst),
      .issue_valid_i(issue_valid), .issue_id_i(issue_id), .issue_ready_o(ready4),
      .id2ctrl_i(id2ctrl),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .wb2ctrl_i(wb2ctrl), .ctrl2ex_o(ex4), .ctrl2wb_o(wb4),
      .outstanding_o(outs4), .busy_o(busy4), .err_o(err4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic drv(input logic iv, input logic [3:0] iid, input logic cv,
                      input logic [3:0] cid, input logic ck, input logic [15:0] clr);
      issue_valid   = iv;
      issue_id      = iid;
      id2ctrl.issue = iv;
      id2ctrl.id    = iid;
      commit_valid  = cv;
      commit_id     = cid;
      commit_kill   = ck;
      wb2ctrl.clear = clr;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic iv, input logic [3:0] iid, input logic cv,
                       input logic [3:0] cid, input logic ck, input logic [15:0] clr);
      drv(iv, iid, cv, cid, ck, clr);
      tick();
      drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0);
   endtask

   task automatic do_reset;
      drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0);
      tick();
      do_reset();

      // Reset state
      check("rst_issue", ex.issue, 32'h0);
      check("rst_commit", ex.commit, 32'h0);
      check("rst_kill", ex.kill, 32'h0);
      check("rst_outs", outs, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_err", err, 32'd0);
      check("rst_ready", ready, 32'd1);

      // Basic lifecycle on id 3
      step(1, 3, 0, 0, 0, 16'h0);
      check("life_issue_t1", ex.issue, 32'h0008);
      check("life_outs_t1", outs, 32'd1);
      check("life_busy_t1", busy, 32'd1);
      step(0, 0, 0, 0, 0, 16'h0);
      step(0, 0, 1, 3, 0, 16'h0);
      check("life_commit_t3", ex.commit, 32'h0008);
      check("life_issue_t3", ex.issue, 32'h0008);
      check("life_wb_t3", wb.commit, 32'h0008);
      step(0, 0, 0, 0, 0, 16'h0);
      step(0, 0, 0, 0, 0, 16'h0008);
      check("life_issue_t5", ex.issue, 32'h0);
      check("life_commit_t5", ex.commit, 32'h0);
      check("life_outs_t5", outs, 32'd0);
      check("life_err", err, 32'd0);

      // Kill path on id 5
      do_reset();
      step(1, 5, 0, 0, 0, 16'h0);
      step(0, 0, 1, 5, 1, 16'h0);
      check("kill_pulse", ex.kill, 32'h0020);
      check("kill_issue_low", ex.issue, 32'h0);
      check("kill_outs", outs, 32'd1);
      drv(1, 5, 0, 0, 0, 16'h0);
      #1;
      check("kill_ready_while_killed", ready, 32'd0);
      tick();
      drv(0, 0, 0, 0, 0, 16'h0);
      check("kill_pulse_gone", ex.kill, 32'h0);
      check("kill_not_reissued", ex.issue, 32'h0);
      check("kill_outs_free", outs, 32'd0);
      step(1, 5, 0, 0, 0, 16'h0);
      check("kill_reissue", ex.issue, 32'h0020);
      check("kill_err", err, 32'd0);

      // Backpressure on the 4-deep instance
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 4'(i), 0, 0, 0, 16'h0);
      check("bp_outs", outs4, 32'd4);
      check("bp_issue", ex4.issue, 32'h000F);
      drv(0, 4, 0, 0, 0, 16'h0);
      #1;
      check("bp_ready_full", ready4, 32'd0);
      check("bp_ready_big", ready, 32'd1);
      step(0, 0, 1, 1, 0, 16'h0);
      drv(0, 4, 0, 0, 0, 16'h0);
      #1;
      check("bp_ready_committed", ready4, 32'd0);
      step(0, 0, 0, 0, 0, 16'h0002);
      drv(0, 4, 0, 0, 0, 16'h0);
      #1;
      check("bp_ready_back", ready4, 32'd1);
      check("bp_outs_after", outs4, 32'd3);
      drv(0, 2, 0, 0, 0, 16'h0);
      #1;
      check("bp_dup_issue", ready4, 32'd0);
      drv(0, 0, 0, 0, 0, 16'h0);

      // Simultaneous events
      do_reset();
      step(1, 0, 0, 0, 0, 16'h0);
      step(1, 2, 0, 0, 0, 16'h0);
      step(0, 0, 1, 0, 0, 16'h0);
      check("sim_pre_issue", ex.issue, 32'h0005);
      check("sim_pre_commit", ex.commit, 32'h0001);
      step(1, 7, 1, 2, 0, 16'h0001);
      check("sim_issue", ex.issue, 32'h0084);
      check("sim_commit", ex.commit, 32'h0004);
      check("sim_outs", outs, 32'd2);
      step(0, 0, 1, 7, 0, 16'h0);
      step(0, 0, 1, 7, 0, 16'h0080);
      check("sim_cc_issue", ex.issue, 32'h0004);
      check("sim_cc_outs", outs, 32'd1);
      check("sim_cc_err", err, 32'd0);
      step(0, 0, 1, 2, 1, 16'h0004);
      check("sim_kc_kill", ex.kill, 32'h0004);
      check("sim_kc_issue", ex.issue, 32'h0);
      check("sim_kc_err", err, 32'd0);
      step(0, 0, 0, 0, 0, 16'h0);
      check("sim_kc_after", ex.kill, 32'h0);
      check("sim_outs_end", outs, 32'd0);

      // Protocol errors
      do_reset();
      step(1, 8, 1, 8, 0, 16'h0);
      check("err_same_cycle", err, 32'd1);
      check("err_same_issue", ex.issue, 32'h0100);
      check("err_same_commit", ex.commit, 32'h0);
      do_reset();
      step(0, 0, 1, 9, 0, 16'h0);
      check("err_commit_free", err, 32'd1);
      check("err_commit_free_vec", ex.issue, 32'h0);
      check("err_commit_free_outs", outs, 32'd0);
      step(1, 4, 0, 0, 0, 16'h0);
      step(0, 0, 0, 0, 0, 16'h0010);
      check("err_clear_issued_vec", ex.issue, 32'h0010);
      check("err_clear_issued_cm", ex.commit, 32'h0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 16'h0);
      check("err_sticky", err, 32'd1);
      do_reset();
      check("err_cleared", err, 32'd0);

      // Reset mid-flight
      for (int i = 0; i < 6; i++) step(1, 4'(i), 0, 0, 0, 16'h0);
      step(0, 0, 1, 1, 0, 16'h0);
      step(0, 0, 1, 3, 0, 16'h0);
      step(0, 0, 1, 5, 0, 16'h0);
      check("mid_issue", ex.issue, 32'h003F);
      check("mid_commit", ex.commit, 32'h002A);
      check("mid_outs", outs, 32'd6);
      do_reset();
      check("mid_rst_issue", ex.issue, 32'h0);
      check("mid_rst_commit", ex.commit, 32'h0);
      check("mid_rst_kill", ex.kill, 32'h0);
      check("mid_rst_outs", outs, 32'd0);
      check("mid_rst_busy", busy, 32'd0);
      check("mid_rst_err", err, 32'd0);
      step(0, 0, 0, 0, 0, 16'h0);
      check("mid_no_kill", ex.kill, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
